button_conditioner: RTL and testbench

Front-end stage between the raw board push-buttons (KEY[3:0], active-low, bouncy, asynchronous) and the memory-game core. It synchronises and debounces the buttons. For each debounced press it emits exactly one single-cycle pulse, carrying the 2-bit button code used by the game sequence encoding. It rejects multi-button chords and keeps a running count of accepted presses for the HEX display.

---
 rtl/button_conditioner_if.sv | 21 ++
 rtl/button_conditioner.sv | 126 ++++++++++++
 tb/tb_button_conditioner.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// Button front-end bus: raw active-low KEY inputs in, debounced press events out.
// master = conditioner side, slave = game-core / stimulus side.
interface button_conditioner_if;
  logic [3:0] buttons;
  logic       press_valid;
  logic [1:0] press_code;
  logic [3:0] press_onehot;
  logic       held;
  logic       chord_error;
  logic [7:0] press_count;

  modport master (
    input  buttons,
    output press_valid, press_code, press_onehot, held, chord_error, press_count
  );

  modport slave (
    output buttons,
    input  press_valid, press_code, press_onehot, held, chord_error, press_count
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises and debounces KEY[3:0], emitting one strobe per accepted single-button
// press, rejecting chords, and counting accepted presses modulo 256.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input logic                  clock,
  input logic                  resetn,
  button_conditioner_if.master bus
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] DB_PRESS   = 2'd1;
  localparam logic [1:0] PRESSED    = 2'd2;
  localparam logic [1:0] DB_RELEASE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       state;
  logic [3:0]       sync1;
  logic [3:0]       p;
  logic [3:0]       cap;
  logic [CNT_W-1:0] cnt;
  logic             cap_onehot;
  logic [1:0]       cap_code;

  logic             press_valid;
  logic [1:0]       press_code;
  logic [3:0]       press_onehot;
  logic             chord_error;
  logic [7:0]       press_count;

  // Inversion folded into the first flop so p is active-high.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      p     <= '0;
    end else begin
      sync1 <= ~bus.buttons;
      p     <= sync1;
    end
  end

  always_comb begin
    cap_onehot = (cap != '0) && ((cap & (cap - 4'd1)) == '0);
    cap_code   = 2'd0;
    case (cap)
      4'b0010: cap_code = 2'd1;
      4'b0100: cap_code = 2'd2;
      4'b1000: cap_code = 2'd3;
      default: cap_code = 2'd0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cap          <= '0;
      cnt          <= '0;
      press_valid  <= 1'b0;
      press_code   <= '0;
      press_onehot <= '0;
      chord_error  <= 1'b0;
      press_count  <= '0;
    end else begin
      press_valid  <= 1'b0;
      press_code   <= '0;
      press_onehot <= '0;
      chord_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (p != '0) begin
            cap   <= p;
            cnt   <= '0;
            state <= DB_PRESS;
          end
        end
        DB_PRESS: begin
          // Pattern change wins over reaching the terminal count.
          if (p == '0) begin
            state <= IDLE;
          end else if (p != cap) begin
            cap <= p;
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= PRESSED;
            if (cap_onehot) begin
              press_valid  <= 1'b1;
              press_code   <= cap_code;
              press_onehot <= cap;
              press_count  <= press_count + 8'd1;
            end else begin
              chord_error  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (p == '0) begin
            cnt   <= '0;
            state <= DB_RELEASE;
          end
        end
        DB_RELEASE: begin
          if (p != '0) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.press_valid  = press_valid;
  assign bus.press_code   = press_code;
  assign bus.press_onehot = press_onehot;
  assign bus.chord_error  = chord_error;
  assign bus.press_count  = press_count;
  assign bus.held         = (state == PRESSED) || (state == DB_RELEASE);

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4: vector table for
// press/bounce/chord/ignore cases, hand sequences for reset abort and count wrap.
module tb_button_conditioner;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  keys;
    int unsigned n;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];

  // {press_valid, press_code, press_onehot, held, chord_error, press_count}
  function automatic logic [16:0] pack(logic v, logic [1:0] code, logic [3:0] oh,
                                       logic h, logic ch, logic [7:0] cnt);
    return {v, code, oh, h, ch, cnt};
  endfunction

  function automatic logic [16:0] outs();
    return {bus.press_valid, bus.press_code, bus.press_onehot, bus.held,
            bus.chord_error, bus.press_count};
  endfunction

  task automatic add(logic [3:0] keys, int unsigned n, logic v, logic [1:0] code,
                     logic [3:0] oh, logic h, logic ch, logic [7:0] cnt);
    vec_t t;
    t.keys = keys;
    t.n    = n;
    t.exp  = pack(v, code, oh, h, ch, cnt);
    vecs.push_back(t);
  endtask

  task automatic check(string name, logic [16:0] got, logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int unsigned pulses;
    logic [7:0]  exp_count;

    bus.buttons = 4'b1111;
    repeat (3) tick();
    check("reset_state", outs(), '0);
    resetn = 1'b1;
    tick();
    check("after_reset", outs(), '0);

    // KEY2 held 20 edges then released
    add(4'b1011, 6,  0, 2'd0, 4'b0000, 0, 0, 8'd0);
    add(4'b1011, 1,  1, 2'd2, 4'b0100, 1, 0, 8'd1);
    add(4'b1011, 13, 0, 2'd0, 4'b0000, 1, 0, 8'd1);
    add(4'b1111, 6,  0, 2'd0, 4'b0000, 1, 0, 8'd1);
    add(4'b1111, 3,  0, 2'd0, 4'b0000, 0, 0, 8'd1);
    // KEY0 bouncing every 2 cycles, then held
    add(4'b1110, 2,  0, 2'd0, 4'b0000, 0, 0, 8'd1);
    add(4'b1111, 2,  0, 2'd0, 4'b0000, 0, 0, 8'd1);
    add(4'b1110, 2,  0, 2'd0, 4'b0000, 0, 0, 8'd1);
    add(4'b1111, 2,  0, 2'd0, 4'b0000, 0, 0, 8'd1);
    add(4'b1110, 6,  0, 2'd0, 4'b0000, 0, 0, 8'd1);
    add(4'b1110, 1,  1, 2'd0, 4'b0001, 1, 0, 8'd2);
    add(4'b1110, 3,  0, 2'd0, 4'b0000, 1, 0, 8'd2);
    add(4'b1111, 6,  0, 2'd0, 4'b0000, 1, 0, 8'd2);
    add(4'b1111, 3,  0, 2'd0, 4'b0000, 0, 0, 8'd2);
    // KEY1+KEY3 chord
    add(4'b0101, 6,  0, 2'd0, 4'b0000, 0, 0, 8'd2);
    add(4'b0101, 1,  0, 2'd0, 4'b0000, 1, 1, 8'd2);
    add(4'b0101, 3,  0, 2'd0, 4'b0000, 1, 0, 8'd2);
    add(4'b1111, 6,  0, 2'd0, 4'b0000, 1, 0, 8'd2);
    add(4'b1111, 3,  0, 2'd0, 4'b0000, 0, 0, 8'd2);
    // KEY3 alone
    add(4'b0111, 6,  0, 2'd0, 4'b0000, 0, 0, 8'd2);
    add(4'b0111, 1,  1, 2'd3, 4'b1000, 1, 0, 8'd3);
    add(4'b0111, 3,  0, 2'd0, 4'b0000, 1, 0, 8'd3);
    add(4'b1111, 6,  0, 2'd0, 4'b0000, 1, 0, 8'd3);
    add(4'b1111, 3,  0, 2'd0, 4'b0000, 0, 0, 8'd3);
    // KEY1, then KEY2 added while pressed: ignored
    add(4'b1101, 6,  0, 2'd0, 4'b0000, 0, 0, 8'd3);
    add(4'b1101, 1,  1, 2'd1, 4'b0010, 1, 0, 8'd4);
    add(4'b1101, 2,  0, 2'd0, 4'b0000, 1, 0, 8'd4);
    add(4'b1001, 5,  0, 2'd0, 4'b0000, 1, 0, 8'd4);
    add(4'b1111, 6,  0, 2'd0, 4'b0000, 1, 0, 8'd4);
    add(4'b1111, 3,  0, 2'd0, 4'b0000, 0, 0, 8'd4);

    foreach (vecs[i]) begin
      for (int unsigned j = 0; j < vecs[i].n; j++) begin
        bus.buttons = vecs[i].keys;
        tick();
        check($sformatf("vec%0d_cyc%0d", i, j), outs(), vecs[i].exp);
      end
    end

    // Reset while debouncing KEY1 at cnt=2; button stays held through reset
    bus.buttons = 4'b1101;
    repeat (5) tick();
    check("pre_reset_quiet", outs(), pack(0, 2'd0, 4'b0000, 0, 0, 8'd4));
    resetn = 1'b0;
    #1;
    check("mid_reset", outs(), '0);
    repeat (2) tick();
    check("mid_reset_held", outs(), '0);
    resetn = 1'b1;
    for (int unsigned j = 0; j < 6; j++) begin
      tick();
      check($sformatf("post_reset_cyc%0d", j), outs(), '0);
    end
    tick();
    check("post_reset_press", outs(), pack(1, 2'd1, 4'b0010, 1, 0, 8'd1));
    bus.buttons = 4'b1111;
    repeat (9) tick();
    check("post_reset_idle", outs(), pack(0, 2'd0, 4'b0000, 0, 0, 8'd1));

    // 256 single presses cycling through keys: count wraps back to start
    pulses    = 0;
    exp_count = 8'd1;
    for (int unsigned i = 0; i < 256; i++) begin
      logic [3:0] k;
      k = 4'b0001 << (i % 4);
      bus.buttons = ~k;
      for (int unsigned j = 0; j < 16; j++) begin
        if (j == 8) bus.buttons = 4'b1111;
        tick();
        if (bus.press_valid === 1'b1) begin
          pulses++;
          exp_count = exp_count + 8'd1;
          check($sformatf("wrap_press%0d", i), outs(),
                pack(1, 2'(i % 4), k, 1, 0, exp_count));
        end
      end
    end
    checks++;
    if (pulses != 256) begin
      errors++;
      $display("FAIL wrap_pulses: got %0d expected 256", pulses);
    end
    check("wrap_final", outs(), pack(0, 2'd0, 4'b0000, 0, 0, 8'd1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
